// File: rtl/clock_divider.sv
// Integer clock divider producing a 50% duty clk_out and a rising-edge tick.
// Odd ratios use a half-cycle-delayed copy to stretch the high phase.
module clock_divider #(
  parameter int divisor = 2
) (
  input  logic clk_in,
  input  logic rst,
  output logic clk_out,
  output logic tick
);

  if (divisor < 1 || divisor > 65535) begin : g_bad
    $error("clock_divider: divisor %0d outside 1..65535", divisor);
  end

  if (divisor == 1) begin : g_pass

    assign clk_out = clk_in & rst;
    assign tick    = rst;

  end else begin : g_div

    localparam int CW = $clog2(divisor);
    localparam logic [CW-1:0] LAST = CW'(divisor - 1);
    localparam logic [CW-1:0] HALF = CW'(divisor / 2);

    logic [CW-1:0] r_cnt;
    logic          r_pos;
    logic          r_tick;

    // r_cnt holds the phase about to start on the next rising edge
    always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
        r_cnt  <= '0;
        r_pos  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        r_pos  <= (r_cnt < HALF);
        r_tick <= (r_cnt == '0);
      end
    end

    assign tick = r_tick;

    if (divisor % 2 == 0) begin : g_even

      assign clk_out = r_pos;

    end else begin : g_odd

      logic r_neg;

      // r_neg overlaps r_pos's fall, so the OR never dips low
      always_ff @(negedge clk_in or negedge rst) begin
        if (!rst) begin
          r_neg <= 1'b0;
        end else begin
          r_neg <= r_pos;
        end
      end

      assign clk_out = r_pos | r_neg;

    end

  end

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider at N = 1,2,3,4,5,7 sharing one clock and reset.
// Expected vectors are queued per half cycle and compared by a monitor.
`timescale 1ns/1ps
module tb_clock_divider;

  typedef struct packed {
    logic [5:0] out;
    logic [5:0] tick;
  } exp_t;

  localparam int NS [6] = '{1, 2, 3, 4, 5, 7};
  localparam longint PER [6] = '{0, 2000, 3000, 4000, 5000, 7000};
  localparam longint HI  [6] = '{0, 1000, 1500, 2000, 2500, 3500};

  bit         clk;
  logic       rst;
  logic [5:0] w_out;
  logic [5:0] w_tick;

  exp_t q [$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   k      = 0;
  int   epoch  = 0;
  bit   pos    = 0;
  bit   done   = 0;

  always #500 clk = ~clk;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    clock_divider #(.divisor(NS[g])) u_dut (
      .clk_in (clk),
      .rst    (rst),
      .clk_out(w_out[g]),
      .tick   (w_tick[g])
    );
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  function automatic exp_t model(input bit p_half);
    exp_t e;
    e = '0;
    if (!rst) return e;
    e.out[0]  = p_half;
    e.tick[0] = 1'b1;
    if (k == 0) return e;
    for (int i = 1; i < 6; i++) begin
      int p;
      p = (k - 1) % NS[i];
      e.out[i]  = p_half ? (4 * p + 1 < 2 * NS[i])
                         : (4 * p + 3 < 2 * NS[i]);
      e.tick[i] = (p == 0);
    end
    return e;
  endfunction

  // set_rst: -1 keep, 0 assert, 1 release (applied mid half-cycle)
  task automatic half(input int set_rst);
    @(clk);
    pos = clk;
    if (pos && rst) k++;
    #100;
    if (set_rst >= 0) begin
      rst = set_rst[0];
      if (!rst) k = 0;
      else epoch++;
    end
    #1;
    if (set_rst == 0) begin
      chk("async_clear_out", w_out, 0);
      chk("async_clear_tick", w_tick, 0);
    end
    #99;
    q.push_back(model(pos));
  endtask

  initial begin
    rst = 1'b0;
    repeat (5) half(-1);
    half(1);
    repeat (4000) half(-1);
    while (!(pos && (k - 1) % 5 == 0)) half(-1);
    half(-1);
    half(0);
    repeat (3) half(-1);
    half(1);
    repeat (6000) half(-1);
    half(0);
    repeat (3) half(-1);
    half(1);
    repeat (28000) half(-1);
    done = 1;
    #1000;
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    exp_t e;
    while (!done) begin
      @(clk);
      #250;
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL underflow: no expected vector at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("clk_out", w_out, e.out);
        chk("tick", w_tick, e.tick);
      end
    end
  end

  for (genvar g = 1; g < 6; g++) begin : g_per
    longint t_rise = 0;
    int     ep     = -1;
    bit     have   = 0;

    always @(posedge w_out[g]) begin
      if (have && ep == epoch)
        chk($sformatf("period_N%0d", NS[g]), $time - t_rise, PER[g]);
      t_rise = $time;
      ep     = epoch;
      have   = 1;
    end

    always @(negedge w_out[g]) begin
      if (rst && have && ep == epoch)
        chk($sformatf("high_N%0d", NS[g]), $time - t_rise, HI[g]);
    end
  end

  initial begin
    #100_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
